// File: rtl/alu_dispatch.sv
// Dispatcher between a request/result handshake and an external add/sub unit.
// Operands are latched on acceptance, issued for one cycle, and the result is captured LAT cycles later.
module alu_dispatch #(
    parameter int unsigned LAT = 1
) (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic [31:0] ALU_dat1,
    output logic [31:0] ALU_dat2,
    output logic [2:0]  ALU_opcode,
    output logic [3:0]  decryptedOP,
    output logic        dat_ready,
    input  logic [31:0] AddSub_out,
    input  logic        AddSub_overflow,
    input  logic        AddSub_zero,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_overflow,
    output logic        res_zero,
    output logic        res_err,
    output logic [4:0]  res_rd,
    output logic [15:0] ops_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [2:0] LAT_CNT = 3'(LAT);

    state_t      state;
    logic [2:0]  cnt;
    logic [4:0]  rd_q;

    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_q         <= '0;
            req_ready    <= 1'b1;
            ALU_dat1     <= '0;
            ALU_dat2     <= '0;
            ALU_opcode   <= '0;
            decryptedOP  <= '0;
            dat_ready    <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_overflow <= 1'b0;
            res_zero     <= 1'b0;
            res_err      <= 1'b0;
            res_rd       <= '0;
            ops_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ALU_opcode <= req_funct3;
                        rd_q       <= req_rd;
                        req_ready  <= 1'b0;
                        if (req_op == 4'd6 || req_op == 4'd7) begin
                            ALU_dat1    <= req_a;
                            ALU_dat2    <= req_b;
                            decryptedOP <= req_op;
                            dat_ready   <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            // Illegal opcode completes immediately; the unit never sees it.
                            res_data     <= '0;
                            res_overflow <= 1'b0;
                            res_zero     <= 1'b0;
                            res_err      <= 1'b1;
                            res_rd       <= req_rd;
                            res_valid    <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    dat_ready <= 1'b0;
                    cnt       <= LAT_CNT;
                    state     <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        res_data     <= AddSub_out;
                        res_overflow <= AddSub_overflow;
                        res_zero     <= AddSub_zero;
                        res_err      <= 1'b0;
                        res_rd       <= rd_q;
                        res_valid    <= 1'b1;
                        ALU_dat1     <= '0;
                        ALU_dat2     <= '0;
                        decryptedOP  <= '0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        req_ready <= 1'b1;
                        ops_count <= ops_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch: one instance at LAT=1, one at LAT=3, each held in reset while the other is exercised.
module tb_alu_dispatch;

    logic        clk;
    logic        rst1, rst3;
    logic        req_valid, res_ready;
    logic [3:0]  req_op;
    logic [2:0]  req_funct3;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_rd;

    logic        rr1, dr1, rv1, ov1, zr1, er1, uo1, uz1;
    logic [31:0] d11, d21, rd1_data, uout1;
    logic [2:0]  fo1;
    logic [3:0]  op1;
    logic [4:0]  rrd1;
    logic [15:0] cnt1;

    logic        rr3, dr3, rv3, ov3, zr3, er3, uo3, uz3;
    logic [31:0] d13, d23, rd3_data, uout3;
    logic [2:0]  fo3;
    logic [3:0]  op3;
    logic [4:0]  rrd3;
    logic [15:0] cnt3;

    // Observed outputs of whichever instance is under test
    logic        sel3;
    logic        o_req_ready, o_dat_ready, o_res_valid, o_ov, o_zero, o_err;
    logic [31:0] o_dat1, o_dat2, o_data;
    logic [2:0]  o_funct;
    logic [3:0]  o_op;
    logic [4:0]  o_rd;
    logic [15:0] o_cnt;

    int errors = 0;
    int checks = 0;

    alu_dispatch #(.LAT(1)) u1 (
        .soc_clk(clk), .reset(rst1), .req_valid(req_valid), .req_ready(rr1),
        .req_op(req_op), .req_funct3(req_funct3), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .ALU_dat1(d11), .ALU_dat2(d21), .ALU_opcode(fo1), .decryptedOP(op1), .dat_ready(dr1),
        .AddSub_out(uout1), .AddSub_overflow(uo1), .AddSub_zero(uz1),
        .res_valid(rv1), .res_ready(res_ready), .res_data(rd1_data), .res_overflow(ov1),
        .res_zero(zr1), .res_err(er1), .res_rd(rrd1), .ops_count(cnt1)
    );

    alu_dispatch #(.LAT(3)) u3 (
        .soc_clk(clk), .reset(rst3), .req_valid(req_valid), .req_ready(rr3),
        .req_op(req_op), .req_funct3(req_funct3), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .ALU_dat1(d13), .ALU_dat2(d23), .ALU_opcode(fo3), .decryptedOP(op3), .dat_ready(dr3),
        .AddSub_out(uout3), .AddSub_overflow(uo3), .AddSub_zero(uz3),
        .res_valid(rv3), .res_ready(res_ready), .res_data(rd3_data), .res_overflow(ov3),
        .res_zero(zr3), .res_err(er3), .res_rd(rrd3), .ops_count(cnt3)
    );

    // Add/sub unit model: sub is a + ~b + 1, overflow is the raw carry out
    function automatic logic [33:0] unit(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [32:0] s;
        if (op == 4'd7) s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        else            s = {1'b0, a} + {1'b0, b};
        return {s[32], (s[31:0] == 32'd0), s[31:0]};
    endfunction

    always_comb begin
        {uo1, uz1, uout1} = unit(d11, d21, op1);
        {uo3, uz3, uout3} = unit(d13, d23, op3);
    end

    always_comb begin
        o_req_ready = sel3 ? rr3 : rr1;
        o_dat_ready = sel3 ? dr3 : dr1;
        o_res_valid = sel3 ? rv3 : rv1;
        o_ov        = sel3 ? ov3 : ov1;
        o_zero      = sel3 ? zr3 : zr1;
        o_err       = sel3 ? er3 : er1;
        o_dat1      = sel3 ? d13 : d11;
        o_dat2      = sel3 ? d23 : d21;
        o_data      = sel3 ? rd3_data : rd1_data;
        o_funct     = sel3 ? fo3 : fo1;
        o_op        = sel3 ? op3 : op1;
        o_rd        = sel3 ? rrd3 : rrd1;
        o_cnt       = sel3 ? cnt3 : cnt1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one request, then scramble req_* and wait (bounded) for res_valid.
    // lat = edges after the acceptance edge until res_valid is seen (-1 on timeout).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output logic [3:0] dop, output int dat_hi);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd; req_funct3 = 3'd5;
        step();
        req_valid = 1'b0; req_op = 4'hF; req_a = $urandom; req_b = $urandom; req_rd = 5'd31;
        dop = o_op;
        lat = -1;
        dat_hi = 0;
        for (int i = 0; i <= 20; i++) begin
            if (o_dat_ready) dat_hi++;
            if (o_res_valid) begin
                lat = i;
                break;
            end
            step();
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        sel3 = 1'b0;
        rst1 = 1'b0; rst3 = 1'b0;
        req_valid = 1'b0; res_ready = 1'b0;
        req_op = '0; req_funct3 = '0; req_a = '0; req_b = '0; req_rd = '0;
        repeat (3) step();
        rst1 = 1'b1;
        #2;
        checks++;
        if (o_req_ready !== 1'b1 || o_dat_ready !== 1'b0 || o_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: req_ready=%b dat_ready=%b res_valid=%b, want 1 0 0", o_req_ready, o_dat_ready, o_res_valid);
        end
        checks++;
        if ({o_dat1, o_dat2, o_op, o_funct, o_data, o_ov, o_zero, o_err, o_rd, o_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: dat1=%h dat2=%h op=%h data=%h err=%b rd=%0d cnt=%0d, want all 0",
                     o_dat1, o_dat2, o_op, o_data, o_err, o_rd, o_cnt);
        end
    endtask

    task automatic test_add();
        req_valid = 1'b1; req_op = 4'd6; req_a = 32'd5; req_b = 32'd7; req_rd = 5'd3; req_funct3 = 3'd2;
        step();
        req_valid = 1'b0; req_op = 4'd9; req_a = 32'hDEAD; req_b = 32'hBEEF; req_funct3 = 3'd7;
        checks++;
        if (o_dat_ready !== 1'b1 || o_op !== 4'd6 || o_dat1 !== 32'd5 || o_dat2 !== 32'd7 || o_funct !== 3'd2 || o_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_issue: dat_ready=%b op=%0d dat1=%0d dat2=%0d funct=%0d req_ready=%b, want 1 6 5 7 2 0",
                     o_dat_ready, o_op, o_dat1, o_dat2, o_funct, o_req_ready);
        end
        step();
        checks++;
        if (o_dat_ready !== 1'b0 || o_dat1 !== 32'd5 || o_op !== 4'd6 || o_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_wait: dat_ready=%b dat1=%0d op=%0d res_valid=%b, want 0 5 6 0", o_dat_ready, o_dat1, o_op, o_res_valid);
        end
        step();
        checks++;
        if (o_res_valid !== 1'b1 || o_data !== 32'd12 || o_ov !== 1'b0 || o_zero !== 1'b0 || o_err !== 1'b0 || o_rd !== 5'd3) begin
            errors++;
            $display("FAIL add_result: valid=%b data=%0d ov=%b zero=%b err=%b rd=%0d, want 1 12 0 0 0 3",
                     o_res_valid, o_data, o_ov, o_zero, o_err, o_rd);
        end
        checks++;
        if (o_dat1 !== 32'd0 || o_dat2 !== 32'd0 || o_op !== 4'd0 || o_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_done_clear: dat1=%0d dat2=%0d op=%0d req_ready=%b, want 0 0 0 0", o_dat1, o_dat2, o_op, o_req_ready);
        end
        handshake();
        checks++;
        if (o_res_valid !== 1'b0 || o_req_ready !== 1'b1 || o_cnt !== 16'd1) begin
            errors++;
            $display("FAIL add_handshake: res_valid=%b req_ready=%b cnt=%0d, want 0 1 1", o_res_valid, o_req_ready, o_cnt);
        end
    endtask

    task automatic test_sub();
        int lat, dh;
        logic [3:0] dop;
        run_op(4'd7, 32'd9, 32'd9, 5'd4, lat, dop, dh);
        checks++;
        if (lat !== 2 || dop !== 4'd7 || dh !== 1) begin
            errors++;
            $display("FAIL sub_timing: lat=%0d op=%0d dat_ready_cycles=%0d, want 2 7 1", lat, dop, dh);
        end
        checks++;
        if (o_data !== 32'd0 || o_zero !== 1'b1 || o_ov !== 1'b1 || o_err !== 1'b0 || o_rd !== 5'd4) begin
            errors++;
            $display("FAIL sub_result: data=%0d zero=%b ov=%b err=%b rd=%0d, want 0 1 1 0 4", o_data, o_zero, o_ov, o_err, o_rd);
        end
        handshake();
    endtask

    task automatic test_add_wrap();
        int lat, dh;
        logic [3:0] dop;
        run_op(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd5, lat, dop, dh);
        checks++;
        if (lat !== 2 || o_data !== 32'd0 || o_ov !== 1'b1 || o_zero !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap: lat=%0d data=%h ov=%b zero=%b, want 2 0 1 1", lat, o_data, o_ov, o_zero);
        end
        handshake();
        checks++;
        if (o_cnt !== 16'd3) begin
            errors++;
            $display("FAIL wrap_count: cnt=%0d, want 3", o_cnt);
        end
    endtask

    task automatic test_illegal();
        int lat, dh;
        logic [3:0] dop;
        run_op(4'd3, 32'd100, 32'd200, 5'd17, lat, dop, dh);
        checks++;
        if (lat !== 0 || dh !== 0 || dop !== 4'd0 || o_dat1 !== 32'd0) begin
            errors++;
            $display("FAIL illegal_timing: lat=%0d dat_ready_cycles=%0d op=%0d dat1=%0d, want 0 0 0 0", lat, dh, dop, o_dat1);
        end
        checks++;
        if (o_err !== 1'b1 || o_data !== 32'd0 || o_ov !== 1'b0 || o_zero !== 1'b0 || o_rd !== 5'd17 || o_cnt !== 16'd3) begin
            errors++;
            $display("FAIL illegal_result: err=%b data=%0d ov=%b zero=%b rd=%0d cnt=%0d, want 1 0 0 0 17 3",
                     o_err, o_data, o_ov, o_zero, o_rd, o_cnt);
        end
        handshake();
        checks++;
        if (o_cnt !== 16'd4 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_count: cnt=%0d req_ready=%b, want 4 1", o_cnt, o_req_ready);
        end
    endtask

    task automatic test_backpressure();
        int lat, dh, bad;
        logic [3:0] dop;
        run_op(4'd6, 32'd2, 32'd3, 5'd9, lat, dop, dh);
        bad = 0;
        req_valid = 1'b1; req_op = 4'd7; req_a = 32'd50; req_b = 32'd1; req_rd = 5'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_res_valid !== 1'b1 || o_data !== 32'd5 || o_rd !== 5'd9 || o_err !== 1'b0 ||
                o_req_ready !== 1'b0 || o_dat_ready !== 1'b0) bad++;
        end
        checks++;
        if (lat !== 2 || bad !== 0) begin
            errors++;
            $display("FAIL backpressure_hold: lat=%0d unstable_cycles=%0d, want 2 0", lat, bad);
        end
        req_valid = 1'b0;
        handshake();
        checks++;
        if (o_req_ready !== 1'b1 || o_res_valid !== 1'b0 || o_cnt !== 16'd5) begin
            errors++;
            $display("FAIL backpressure_release: req_ready=%b res_valid=%b cnt=%0d, want 1 0 5", o_req_ready, o_res_valid, o_cnt);
        end
        step();
        checks++;
        if (o_dat_ready !== 1'b0 || o_res_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_ignored: dat_ready=%b res_valid=%b req_ready=%b, want 0 0 1", o_dat_ready, o_res_valid, o_req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int both;
        logic [15:0] c0;
        c0 = o_cnt;
        both = 0;
        req_valid = 1'b1; req_op = 4'd6; req_a = 32'd1; req_b = 32'd1; req_rd = 5'd2;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (o_req_ready && o_res_valid) both++;
        end
        req_valid = 1'b0; res_ready = 1'b0;
        checks++;
        if (o_cnt !== c0 + 16'd2 || both !== 0) begin
            errors++;
            $display("FAIL back_to_back: cnt=%0d overlap=%0d, want %0d 0", o_cnt, both, c0 + 16'd2);
        end
    endtask

    task automatic test_reset_in_wait();
        int lat, dh;
        logic [3:0] dop;
        rst1 = 1'b0;
        sel3 = 1'b1;
        step();
        rst3 = 1'b1;
        req_valid = 1'b1; req_op = 4'd6; req_a = 32'd4; req_b = 32'd4; req_rd = 5'd6;
        step();
        req_valid = 1'b0;
        step();
        step();
        checks++;
        if (o_dat_ready !== 1'b0 || o_dat1 !== 32'd4 || o_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat3_wait: dat_ready=%b dat1=%0d res_valid=%b, want 0 4 0", o_dat_ready, o_dat1, o_res_valid);
        end
        #2 rst3 = 1'b0;
        #1;
        checks++;
        if ({o_dat1, o_dat2, o_op, o_funct, o_data, o_ov, o_zero, o_err, o_rd, o_cnt, o_res_valid, o_dat_ready} !== '0) begin
            errors++;
            $display("FAIL async_reset: dat1=%0d op=%0d funct=%0d valid=%b cnt=%0d, want all 0", o_dat1, o_op, o_funct, o_res_valid, o_cnt);
        end
        repeat (2) step();
        rst3 = 1'b1;
        repeat (4) step();
        checks++;
        if (o_res_valid !== 1'b0 || o_cnt !== 16'd0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_discard: res_valid=%b cnt=%0d req_ready=%b, want 0 0 1", o_res_valid, o_cnt, o_req_ready);
        end
        run_op(4'd6, 32'd1, 32'd1, 5'd8, lat, dop, dh);
        checks++;
        if (lat !== 4 || dh !== 1 || o_data !== 32'd2 || o_ov !== 1'b0 || o_zero !== 1'b0 || o_rd !== 5'd8) begin
            errors++;
            $display("FAIL lat3_add: lat=%0d dat_ready_cycles=%0d data=%0d ov=%b zero=%b rd=%0d, want 4 1 2 0 0 8",
                     lat, dh, o_data, o_ov, o_zero, o_rd);
        end
        handshake();
        checks++;
        if (o_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lat3_count: cnt=%0d, want 1", o_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_add_wrap();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
